lfsr_im_seq: RTL and testbench

Sequencer for the LFSR-based item memory in the HDC seizure-detection datapath. It turns a requested item index into the right number of LFSR load and step commands, so the steppable LFSR's hypervector output equals item `idx`. It then holds that state until the encoder acknowledges it. The controller tracks the LFSR's current position, so ascending requests advance forward from that position instead of reloading from the start value.

---
 rtl/lfsr_im_seq.sv | 152 +++++++++++++++
 tb/tb_lfsr_im_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_im_seq.sv
// Item-memory sequencer: converts an item index into LFSR load/step commands and
// holds the resulting hypervector until the encoder acknowledges it.
module lfsr_im_seq #(
    parameter int NUM_IDX = 64,
    parameter int STRIDE  = 4,
    parameter int IDX_W   = $clog2(NUM_IDX),
    parameter int POS_W   = $clog2(NUM_IDX * STRIDE)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             req_valid,
    input  logic [IDX_W-1:0] req_idx,
    output logic             req_ready,
    output logic             hv_valid,
    input  logic             hv_ack,
    output logic [IDX_W-1:0] cur_idx,
    output logic             lfsr_load,
    output logic             lfsr_step,
    output logic             err,
    output logic [1:0]       dbg_state
);

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and hv_ack is honoured only while hv_valid is high.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_STEP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [IDX_W:0]   NUM_IDX_C = (IDX_W + 1)'(NUM_IDX);
    localparam logic [POS_W-1:0] STRIDE_C  = POS_W'(STRIDE);
    localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);

    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             pos_ok_q, pos_ok_d;
    logic [POS_W-1:0] tgt_q, tgt_d;
    logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
    logic             hv_valid_q, hv_valid_d;
    logic             load_q, load_d;
    logic             step_q, step_d;
    logic             err_q, err_d;

    logic             req_oor;
    logic [POS_W-1:0] req_tgt;
    logic [POS_W-1:0] pos_inc;

    assign req_oor = {1'b0, req_idx} >= NUM_IDX_C;
    assign req_tgt = POS_W'(req_idx) * STRIDE_C;
    assign pos_inc = pos_q + POS_ONE;

    // Output registers are loaded from the next state, so they line up with state_q.
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        pos_ok_d   = pos_ok_q;
        tgt_d      = tgt_q;
        cur_idx_d  = cur_idx_q;
        hv_valid_d = hv_valid_q;
        load_d     = 1'b0;
        step_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_oor) begin
                        err_d = 1'b1;
                    end else begin
                        cur_idx_d = req_idx;
                        tgt_d     = req_tgt;
                        if (pos_ok_q && (req_tgt == pos_q)) begin
                            state_d    = S_HOLD;
                            hv_valid_d = 1'b1;
                        end else if (pos_ok_q && (req_tgt > pos_q)) begin
                            state_d = S_STEP;
                            step_d  = 1'b1;
                        end else begin
                            state_d = S_LOAD;
                            load_d  = 1'b1;
                        end
                    end
                end
            end
            S_LOAD: begin
                pos_d    = '0;
                pos_ok_d = 1'b1;
                if (tgt_q == '0) begin
                    state_d    = S_HOLD;
                    hv_valid_d = 1'b1;
                end else begin
                    state_d = S_STEP;
                    step_d  = 1'b1;
                end
            end
            S_STEP: begin
                pos_d = pos_inc;
                if (pos_inc == tgt_q) begin
                    state_d    = S_HOLD;
                    hv_valid_d = 1'b1;
                end else begin
                    step_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (hv_ack) begin
                    state_d    = S_IDLE;
                    hv_valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                hv_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            pos_q      <= '0;
            pos_ok_q   <= 1'b0;
            tgt_q      <= '0;
            cur_idx_q  <= '0;
            hv_valid_q <= 1'b0;
            load_q     <= 1'b0;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            pos_ok_q   <= pos_ok_d;
            tgt_q      <= tgt_d;
            cur_idx_q  <= cur_idx_d;
            hv_valid_q <= hv_valid_d;
            load_q     <= load_d;
            step_q     <= step_d;
            err_q      <= err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign hv_valid  = hv_valid_q;
    assign cur_idx   = cur_idx_q;
    assign lfsr_load = load_q;
    assign lfsr_step = step_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lfsr_im_seq.sv
// Bench for lfsr_im_seq: directed scenarios plus random requests, checked against
// an abstract position model and a reference LFSR through an expected queue.
module tb_lfsr_im_seq;
  localparam int NUM_IDX = 64;
  localparam int STRIDE  = 4;
  localparam int IDX_W   = 7;
  localparam int POS_W   = 8;
  localparam logic [15:0] START_VAL = 16'hACE1;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             req_valid = 1'b0;
  logic [IDX_W-1:0] req_idx = '0;
  logic             req_ready;
  logic             hv_valid;
  logic             hv_ack = 1'b0;
  logic [IDX_W-1:0] cur_idx;
  logic             lfsr_load;
  logic             lfsr_step;
  logic             err;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  lfsr_im_seq #(
    .NUM_IDX(NUM_IDX), .STRIDE(STRIDE), .IDX_W(IDX_W), .POS_W(POS_W)
  ) dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_idx(req_idx),
    .req_ready(req_ready), .hv_valid(hv_valid), .hv_ack(hv_ack),
    .cur_idx(cur_idx), .lfsr_load(lfsr_load), .lfsr_step(lfsr_step),
    .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference LFSR ----------------
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] item_hv(input int idx);
    logic [15:0] v;
    v = START_VAL;
    for (int i = 0; i < idx * STRIDE; i++) v = lfsr_next(v);
    return v;
  endfunction

  logic [15:0] lfsr_q = 16'h0;
  always @(posedge clk) begin
    if (lfsr_load) lfsr_q <= START_VAL;
    else if (lfsr_step) lfsr_q <= lfsr_next(lfsr_q);
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic             is_err;
    logic [IDX_W-1:0] idx;
    logic [15:0]      hv;
    logic [8:0]       lat;
    logic [8:0]       loads;
    logic [8:0]       steps;
  } exp_t;
  exp_t exp_q[$];

  int m_pos = 0;
  bit m_pos_ok = 1'b0;
  int m_cur = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts load/step cycles since each accept and checks every presented result.
  logic hv_prev = 1'b0;
  int   acc_cyc = 0;
  int   n_load = 0;
  int   n_step = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!nrst) begin
      hv_prev = 1'b0;
    end else begin
      check("load_step_exclusive", {31'b0, lfsr_load & lfsr_step}, 0);
      n_load += int'(lfsr_load);
      n_step += int'(lfsr_step);
      if ((hv_valid && !hv_prev) || err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: hv_valid=%0d err=%0d with nothing expected", hv_valid, err);
        end else begin
          e = exp_q.pop_front();
          check("event_is_err", {31'b0, err}, {31'b0, e.is_err});
          check("latency", cyc - acc_cyc + 1, {23'b0, e.lat});
          check("load_cycles", n_load, {23'b0, e.loads});
          check("step_cycles", n_step, {23'b0, e.steps});
          if (!e.is_err) begin
            check("cur_idx", {25'b0, cur_idx}, {25'b0, e.idx});
            check("lfsr_value", {16'b0, lfsr_q}, {16'b0, e.hv});
          end
        end
      end
      hv_prev = hv_valid;
      if (req_valid && req_ready) begin
        acc_cyc = cyc + 1;
        n_load = 0;
        n_step = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 1);
    check({tag, "_hv_valid"}, {31'b0, hv_valid}, 0);
    check({tag, "_lfsr_load"}, {31'b0, lfsr_load}, 0);
    check({tag, "_lfsr_step"}, {31'b0, lfsr_step}, 0);
    check({tag, "_err"}, {31'b0, err}, 0);
    check({tag, "_cur_idx"}, {25'b0, cur_idx}, 0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pos = 0;
    m_pos_ok = 1'b0;
    m_cur = 0;
  endtask

  task automatic do_reset();
    #3;
    nrst = 1'b0;
    #1;
    check_reset_outputs("reset");
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_timeout", {31'b0, req_ready}, 1);
  endtask

  task automatic issue(input int idx);
    exp_t e;
    int   tgt;
    e = '0;
    e.idx = IDX_W'(idx);
    if (idx >= NUM_IDX) begin
      e.is_err = 1'b1;
      e.lat = 9'd1;
    end else begin
      tgt = idx * STRIDE;
      e.hv = item_hv(idx);
      if (m_pos_ok && tgt >= m_pos) begin
        e.steps = 9'(tgt - m_pos);
        e.lat = 9'(1 + tgt - m_pos);
      end else begin
        e.loads = 9'd1;
        e.steps = 9'(tgt);
        e.lat = 9'(2 + tgt);
      end
      m_pos = tgt;
      m_pos_ok = 1'b1;
      m_cur = idx;
    end
    exp_q.push_back(e);
    req_valid = 1'b1;
    req_idx = IDX_W'(idx);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_hv();
    int n = 0;
    while (!hv_valid && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hv_timeout", {31'b0, hv_valid}, 1);
  endtask

  task automatic ack();
    hv_ack = 1'b1;
    @(posedge clk);
    #1;
    hv_ack = 1'b0;
    check("after_ack_hv_valid", {31'b0, hv_valid}, 0);
    check("after_ack_req_ready", {31'b0, req_ready}, 1);
  endtask

  task automatic request(input int idx, input int hold);
    wait_ready();
    issue(idx);
    if (idx < NUM_IDX) begin
      wait_hv();
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      ack();
    end else begin
      check("oor_err_pulse", {31'b0, err}, 1);
      check("oor_req_ready", {31'b0, req_ready}, 1);
      @(posedge clk);
      #1;
      check("oor_err_cleared", {31'b0, err}, 0);
      check("oor_cur_idx_kept", {25'b0, cur_idx}, m_cur);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int last;
    int idx;
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #2;
    nrst = 1'b1;
    @(posedge clk);
    #1;

    request(3, 1);
    request(5, 0);
    request(5, 2);
    request(2, 0);

    do_reset();
    request(0, 0);
    request(64, 0);
    request(127, 0);

    // Long hold: hv_ack low for 20 cycles while another request is pending.
    wait_ready();
    issue(9);
    wait_hv();
    req_valid = 1'b1;
    req_idx = IDX_W'($urandom_range(0, NUM_IDX - 1));
    repeat (20) begin
      @(posedge clk);
      #1;
      check("hold_hv_valid", {31'b0, hv_valid}, 1);
      check("hold_req_ready", {31'b0, req_ready}, 0);
      check("hold_cur_idx", {25'b0, cur_idx}, 9);
    end
    req_valid = 1'b0;
    ack();

    // Reset while stepping towards idx 7.
    wait_ready();
    issue(7);
    repeat (5) @(posedge clk);
    do_reset();
    request(1, 0);

    last = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) idx = int'($urandom_range(0, 70));
      else idx = last + int'($urandom_range(0, 3));
      if (idx < NUM_IDX) last = idx;
      request(idx, int'($urandom_range(0, 3)));
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
